// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Groups the pipeline-facing signals of the next-PC sequencer into one bundle.
//   The slave modport is the sequencer. The master modport is the pipeline or
//   front end that drives hazards and redirects and consumes PC/flush controls.
// Signals
//   pc_cur       current PC register value
//   imem_ready   instruction word at pc_cur valid this cycle
//   load_use     ID-stage load-use hazard
//   jump         ID-stage jump resolved; target on jump_tgt
//   jump_tgt     jump target
//   br_taken     EX-stage branch taken; target on br_tgt
//   br_tgt       branch target
//   exc_req      synchronous exception request
//   exc_pc       PC of the faulting instruction
//   irq          level-sensitive external interrupt
//   eret         ID-stage eret decoded
//   pc_next      PC register input
//   pc_write     PC register write enable
//   pc_flush     PC register clear
//   if_id_write  IF/ID enable
//   if_id_flush  IF/ID bubble
//   id_ex_flush  ID/EX bubble
//   epc          saved return PC
//   kernel       high while handling an exception or interrupt
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic        load_use;
  logic        jump;
  logic [31:0] jump_tgt;
  logic        br_taken;
  logic [31:0] br_tgt;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        irq;
  logic        eret;

  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_flush;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [31:0] epc;
  logic        kernel;

  modport master (
    output pc_cur, imem_ready, load_use, jump, jump_tgt, br_taken, br_tgt,
           exc_req, exc_pc, irq, eret,
    input  pc_next, pc_write, pc_flush, if_id_write, if_id_flush, id_ex_flush,
           epc, kernel
  );

  modport slave (
    input  pc_cur, imem_ready, load_use, jump, jump_tgt, br_taken, br_tgt,
           exc_req, exc_pc, irq, eret,
    output pc_next, pc_write, pc_flush, if_id_write, if_id_flush, id_ex_flush,
           epc, kernel
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Next-PC selection and front-end flow control for the 5-stage pipeline.
//   Each cycle it arbitrates the following sources, from highest priority to lowest:
//   exception (including imem timeout), IRQ, branch, eret, jump, load-use stall,
//   imem wait, and sequential fetch. It owns EPC and the kernel-mode flag.
// Ports
//   clk    clock; all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    pc_sequencer_if.slave (hazard/redirect inputs, PC and pipeline controls)
// Parameters
//   EXC_VECTOR  fetch address on exception or imem timeout
//   IRQ_VECTOR  fetch address on external interrupt
//   IMEM_TMO    consecutive imem wait cycles that raise a bus-error exception (>=2)
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0008,
  parameter int          IMEM_TMO   = 16
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(IMEM_TMO + 1);

  typedef enum logic {ST_RUN, ST_IWAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [31:0]      epc_q, epc_nxt;
  logic             kernel_q, kernel_nxt;

  logic [31:0] pc_seq;
  logic        tmo_hit;
  logic        take_exc;
  logic        take_irq;

  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_flush;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;

  assign pc_seq = bus.pc_cur + 32'd4;

  // The wait counter already holds the previous wait cycles. When it reaches
  // IMEM_TMO-1 and the current cycle is still waiting, that is the IMEM_TMO-th
  // consecutive wait cycle.
  assign tmo_hit  = (state == ST_IWAIT) && !bus.imem_ready &&
                    (tmo_cnt == CNT_W'(IMEM_TMO - 1));
  assign take_exc = bus.exc_req || tmo_hit;

  // An interrupt is taken only on a clean cycle. When it is not taken, it stays
  // pending because irq is level-sensitive.
  assign take_irq = bus.irq && !kernel_q && !bus.br_taken && !bus.jump &&
                    !bus.load_use && (state == ST_RUN) && bus.imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      tmo_cnt  <= '0;
      epc_q    <= '0;
      kernel_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      epc_q    <= epc_nxt;
      kernel_q <= kernel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    epc_nxt     = epc_q;
    kernel_nxt  = kernel_q;
    pc_next     = pc_seq;
    pc_write    = 1'b1;
    pc_flush    = 1'b0;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    if (reset) begin
      pc_write    = 1'b0;
      pc_flush    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (take_exc) begin
      pc_next     = EXC_VECTOR;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      epc_nxt     = tmo_hit ? bus.pc_cur : bus.exc_pc;
      kernel_nxt  = 1'b1;
      state_nxt   = ST_RUN;
      tmo_cnt_nxt = '0;
    end else if (take_irq) begin
      pc_next     = IRQ_VECTOR;
      if_id_flush = 1'b1;
      epc_nxt     = bus.pc_cur;
      kernel_nxt  = 1'b1;
      state_nxt   = ST_RUN;
      tmo_cnt_nxt = '0;
    end else if (bus.br_taken) begin
      pc_next     = bus.br_tgt;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = ST_RUN;
      tmo_cnt_nxt = '0;
    end else if (bus.eret && kernel_q) begin
      pc_next     = epc_q;
      if_id_flush = 1'b1;
      kernel_nxt  = 1'b0;
      state_nxt   = ST_RUN;
      tmo_cnt_nxt = '0;
    end else if (bus.jump) begin
      pc_next     = bus.jump_tgt;
      if_id_flush = 1'b1;
      state_nxt   = ST_RUN;
      tmo_cnt_nxt = '0;
    end else if (bus.load_use) begin
      // A load-use stall freezes the PC and IF/ID and sends one bubble into EX.
      // The imem wait counter is left untouched.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!bus.imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      state_nxt   = ST_IWAIT;
      tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
    end else begin
      state_nxt   = ST_RUN;
      tmo_cnt_nxt = '0;
    end
  end

  assign bus.pc_next     = pc_next;
  assign bus.pc_write    = pc_write;
  assign bus.pc_flush    = pc_flush;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.epc         = epc_q;
  assign bus.kernel      = kernel_q;

endmodule
